// File: rtl/timer_slot_arbiter_if.sv
// timer_slot_arbiter_if: request/delay bundle from clients and grant/done/status back from the arbiter.
// Revision 1.0 - initial release.
`default_nettype none

interface timer_slot_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] delay;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [DW-1:0]      cnt;

  modport master (
    output req, delay,
    input  grant, done, busy, cnt
  );

  modport slave (
    input  req, delay,
    output grant, done, busy, cnt
  );
endinterface

`default_nettype wire

// File: rtl/timer_slot_arbiter.sv
// timer_slot_arbiter: round-robin sharing of one prescaled delay counter among NREQ requesters.
// Revision 1.0 - initial release.
`default_nettype none

module timer_slot_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  timer_slot_arbiter_if.slave  arb
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   d_q, d_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;

  logic [IW-1:0]   win;
  logic [DW-1:0]   win_delay;

  // First asserted request strictly after the last owner, wrapping; the last owner itself is checked last.
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    win   = ptr_q;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && arb.req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign win_delay = arb.delay[win*DW +: DW];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    d_d     = d_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        if (|arb.req) begin
          ptr_d  = win;
          d_d    = win_delay;
          cnt_d  = '0;
          pre_d  = '0;
          busy_d = 1'b1;
          if (win_delay != '0) begin
            state_d = S_RUN;
            grant_d = ONE_HOT0 << win;
          end else begin
            state_d = S_DONE;
            done_d  = ONE_HOT0 << win;
          end
        end
      end

      S_RUN: begin
        // Abort wins over completion: a dropped request never receives done.
        if (!arb.req[ptr_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          cnt_d   = '0;
          pre_d   = '0;
          busy_d  = 1'b0;
        end else if (pre_q == PRE_LAST) begin
          pre_d = '0;
          cnt_d = cnt_q + DW'(1);
          if (cnt_q == d_q - DW'(1)) begin
            state_d = S_DONE;
            grant_d = '0;
            done_d  = grant_q;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        pre_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NREQ - 1);
      d_q     <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      d_q     <= d_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign arb.grant = grant_q;
  assign arb.done  = done_q;
  assign arb.busy  = busy_q;
  assign arb.cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_slot_arbiter.sv
// tb_timer_slot_arbiter: directed checks of timer_slot_arbiter at PRESCALE=1 and PRESCALE=4.
// Revision 1.0 - initial release.
`default_nettype none

module tb_timer_slot_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  timer_slot_arbiter_if #(.NREQ(4), .DW(8)) ifa ();
  timer_slot_arbiter_if #(.NREQ(4), .DW(8)) ifb ();

  timer_slot_arbiter #(.NREQ(4), .DW(8), .PRESCALE(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .arb (ifa)
  );

  timer_slot_arbiter #(.NREQ(4), .DW(8), .PRESCALE(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .arb (ifb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_a(input string tag, input logic [3:0] g, input logic [3:0] d,
                          input logic b, input logic [7:0] c);
    check({tag, ".grant"}, 32'(ifa.grant), 32'(g));
    check({tag, ".done"},  32'(ifa.done),  32'(d));
    check({tag, ".busy"},  32'(ifa.busy),  32'(b));
    check({tag, ".cnt"},   32'(ifa.cnt),   32'(c));
  endtask

  task automatic expect_b(input string tag, input logic [3:0] g, input logic [3:0] d,
                          input logic b, input logic [7:0] c);
    check({tag, ".grant"}, 32'(ifb.grant), 32'(g));
    check({tag, ".done"},  32'(ifb.done),  32'(d));
    check({tag, ".busy"},  32'(ifb.busy),  32'(b));
    check({tag, ".cnt"},   32'(ifb.cnt),   32'(c));
  endtask

  initial begin
    int order [5];
    logic [3:0] oh;
    order = '{0, 1, 2, 3, 0};

    ifa.req = '0; ifa.delay = '0;
    ifb.req = '0; ifb.delay = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    expect_a("rst_a", 4'b0000, 4'b0000, 1'b0, 8'd0);
    expect_b("rst_b", 4'b0000, 4'b0000, 1'b0, 8'd0);
    rst = 1'b1;

    // Single job, delay 3
    ifa.req = 4'b0001; ifa.delay = {8'd0, 8'd0, 8'd0, 8'd3};
    @(negedge clk); expect_a("single_c0", 4'b0001, 4'b0000, 1'b1, 8'd0);
    @(negedge clk); expect_a("single_c1", 4'b0001, 4'b0000, 1'b1, 8'd1);
    @(negedge clk); expect_a("single_c2", 4'b0001, 4'b0000, 1'b1, 8'd2);
    @(negedge clk); expect_a("single_done", 4'b0000, 4'b0001, 1'b1, 8'd3);
    ifa.req = 4'b0000;
    @(negedge clk); expect_a("single_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Round-robin from a fresh reset so requester 0 leads
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    ifa.delay = {4{8'd2}}; ifa.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      oh = 4'b0001 << order[j];
      @(negedge clk); expect_a("rr_run0", oh, 4'b0000, 1'b1, 8'd0);
      @(negedge clk); expect_a("rr_run1", oh, 4'b0000, 1'b1, 8'd1);
      @(negedge clk); expect_a("rr_done", 4'b0000, oh, 1'b1, 8'd2);
      if (j == 4) ifa.req = 4'b0000;
      @(negedge clk); expect_a("rr_gap", 4'b0000, 4'b0000, 1'b0, 8'd0);
    end

    // Zero delay goes straight to done without grant
    ifa.req = 4'b0100; ifa.delay = '0;
    @(negedge clk); expect_a("zero_done", 4'b0000, 4'b0100, 1'b1, 8'd0);
    ifa.req = 4'b0000;
    @(negedge clk); expect_a("zero_after", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Abort: requester 1 drops after 4 RUN cycles; requester 3 must win next
    ifa.req = 4'b0010; ifa.delay = {8'd5, 8'd0, 8'd10, 8'd0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); expect_a("abort_run", 4'b0010, 4'b0000, 1'b1, 8'(i));
    end
    ifa.req = 4'b1000;
    @(negedge clk); expect_a("abort_drop", 4'b0000, 4'b0000, 1'b0, 8'd0);
    ifa.req = 4'b1010;
    @(negedge clk); expect_a("abort_next", 4'b1000, 4'b0000, 1'b1, 8'd0);
    ifa.req = 4'b0000;
    @(negedge clk); expect_a("abort_clear", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Prescale 4, delay 3: 12 grant cycles then done
    ifb.req = 4'b0001; ifb.delay = {8'd0, 8'd0, 8'd0, 8'd3};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); expect_b("pre_run", 4'b0001, 4'b0000, 1'b1, 8'(i / 4));
    end
    @(negedge clk); expect_b("pre_done", 4'b0000, 4'b0001, 1'b1, 8'd3);
    ifb.req = 4'b0000;
    @(negedge clk); expect_b("pre_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Asynchronous reset in the middle of a job
    ifa.req = 4'b0100; ifa.delay = {4{8'd5}};
    @(negedge clk); expect_a("mr_run0", 4'b0100, 4'b0000, 1'b1, 8'd0);
    ifa.req = 4'b1111;
    @(negedge clk); expect_a("mr_run1", 4'b0100, 4'b0000, 1'b1, 8'd1);
    #2 rst = 1'b0;
    #1 expect_a("mr_async", 4'b0000, 4'b0000, 1'b0, 8'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); expect_a("mr_first", 4'b0001, 4'b0000, 1'b1, 8'd0);
    ifa.req = 4'b0000;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
